banqi_board_store: RTL and testbench

Parametrised board storage for the Banqi game. It holds one 5-bit cell per square and loads the standard 32-piece set face-down, either in canonical order or shuffled by a seeded LFSR Fisher-Yates pass. It applies move/capture writes and uncover requests from the game logic, tracks live piece counts per colour, and exports the whole board flattened for the display path.

---
 rtl/banqi_board_store.sv | 259 +++++++++++++++++++++++++
 tb/tb_banqi_board_store.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/banqi_board_store.sv
// banqi_board_store
//   Board storage for a Banqi game. One 5-bit cell per square:
//     bit4 colour (0 red, 1 black), bits3:1 piece (000 = none), bit0 uncovered.
//   An init sequence fills the standard 32-piece set face-down in canonical
//   order, then (when SHUFFLE != 0) permutes it with a Fisher-Yates pass
//   driven by a 16-bit Galois LFSR. Outside init the game logic writes cells
//   and uncovers pieces; live piece counts per colour follow every write.
//
// Ports
//   CLK, RESET_N              clock, asynchronous active-low reset
//   init_start                start fill (+shuffle), honoured in IDLE/DONE only
//   seed_load, seed_in        reload LFSR (0 selects SEED), IDLE/DONE only
//   init_busy, init_done      init in progress / one-cycle completion pulse
//   wr_en, wr_addr, wr_piece  cell write
//   uncover_en, uncover_addr  set the uncovered bit of an occupied cell
//   rd_addr, rd_piece         registered read port, one cycle latency
//   board_flat                all cells, cell k at [k*5 +: 5]
//   red_count, black_count    live pieces per colour, saturating 0..31
//   game_over                 idle after an init and one colour is wiped out
module banqi_board_store #(
  parameter int          ROWS    = 4,
  parameter int          COLS    = 8,
  parameter int          SHUFFLE = 1,
  parameter logic [15:0] SEED    = 16'hACE1,
  localparam int         N       = ROWS * COLS,
  localparam int         ADDR_W  = $clog2(N)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              init_start,
  input  logic              seed_load,
  input  logic [15:0]       seed_in,
  output logic              init_busy,
  output logic              init_done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [4:0]        wr_piece,
  input  logic              uncover_en,
  input  logic [ADDR_W-1:0] uncover_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [4:0]        rd_piece,
  output logic [N*5-1:0]    board_flat,
  output logic [4:0]        red_count,
  output logic [4:0]        black_count,
  output logic              game_over
);

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N - 1);
  localparam bit                DO_SHUFFLE = (SHUFFLE != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_SHUFFLE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            state_r, state_next_s;
  logic [4:0]        cells_r [N];
  logic [ADDR_W-1:0] fill_idx_r;
  logic [ADDR_W-1:0] swap_j_r;
  logic [15:0]       lfsr_r;
  logic [4:0]        red_cnt_r, black_cnt_r;
  logic [4:0]        red_next_s, black_next_s;
  logic              done_seen_r, done_seen_next_s;
  logic              init_busy_r, init_done_r, game_over_r;
  logic [4:0]        rd_piece_r;

  logic              idle_s;
  logic              fill_last_s;
  logic [ADDR_W-1:0] swap_r_s;
  logic              swap_ok_s;
  logic [4:0]        wr_old_s;
  logic              old_live_s, new_live_s;

  // Canonical placement: 0..15 black, 16..31 red, remaining squares empty.
  function automatic logic [4:0] canon_cell(input logic [ADDR_W-1:0] idx);
    int unsigned i;
    logic [2:0]  p;
    i = 32'(idx);
    case (i[3:0])
      4'd0:          p = 3'b111;
      4'd1, 4'd2:    p = 3'b110;
      4'd3, 4'd4:    p = 3'b101;
      4'd5, 4'd6:    p = 3'b011;
      4'd7, 4'd8:    p = 3'b100;
      4'd9, 4'd10:   p = 3'b010;
      default:       p = 3'b001;
    endcase
    if (i >= 32'd32) begin
      return 5'd0;
    end else begin
      return {(i < 32'd16), p, 1'b0};
    end
  endfunction

  // Galois LFSR step, right shift, taps 0xB400.
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Saturating counter update; a simultaneous dec and inc cancel.
  function automatic logic [4:0] cnt_adjust(input logic [4:0] c, input logic dec,
                                            input logic inc);
    if (dec && !inc) begin
      return (c == 5'd0) ? 5'd0 : c - 5'd1;
    end else if (inc && !dec) begin
      return (c == 5'd31) ? 5'd31 : c + 5'd1;
    end else begin
      return c;
    end
  endfunction

  // Shared decode of the current state, shuffle candidate and write target.
  always_comb begin
    idle_s      = (state_r == ST_IDLE) || (state_r == ST_DONE);
    fill_last_s = (fill_idx_r == LAST_IDX);
    swap_r_s    = lfsr_r[ADDR_W-1:0];
    swap_ok_s   = (swap_r_s <= swap_j_r);
    wr_old_s    = cells_r[wr_addr];
    old_live_s  = (wr_old_s[3:1] != 3'd0);
    new_live_s  = (wr_piece[3:1] != 3'd0);
  end

  // Init sequencer next-state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (init_start) state_next_s = ST_FILL;
        else            state_next_s = ST_IDLE;
      end
      ST_FILL: begin
        if (fill_last_s) state_next_s = DO_SHUFFLE ? ST_SHUFFLE : ST_DONE;
        else             state_next_s = ST_FILL;
      end
      ST_SHUFFLE: begin
        // The accepted swap at j = 1 is the last one of the pass.
        if (swap_ok_s && (swap_j_r == ADDR_W'(1))) state_next_s = ST_DONE;
        else                                        state_next_s = ST_SHUFFLE;
      end
      ST_DONE: begin
        if (init_start) state_next_s = ST_FILL;
        else            state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next piece counts: preset at the end of fill, tracked by game writes.
  always_comb begin
    red_next_s   = red_cnt_r;
    black_next_s = black_cnt_r;
    if ((state_r == ST_FILL) && fill_last_s) begin
      red_next_s   = 5'd16;
      black_next_s = 5'd16;
    end else if (idle_s && wr_en) begin
      red_next_s   = cnt_adjust(red_cnt_r,   old_live_s && !wr_old_s[4],
                                             new_live_s && !wr_piece[4]);
      black_next_s = cnt_adjust(black_cnt_r, old_live_s &&  wr_old_s[4],
                                             new_live_s &&  wr_piece[4]);
    end else begin
      red_next_s   = red_cnt_r;
      black_next_s = black_cnt_r;
    end
    done_seen_next_s = done_seen_r || (state_next_s == ST_DONE);
  end

  // Sequencer state, counters, LFSR and registered status outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= ST_IDLE;
      fill_idx_r  <= '0;
      swap_j_r    <= '0;
      lfsr_r      <= SEED;
      red_cnt_r   <= 5'd0;
      black_cnt_r <= 5'd0;
      done_seen_r <= 1'b0;
      init_busy_r <= 1'b0;
      init_done_r <= 1'b0;
      game_over_r <= 1'b0;
      rd_piece_r  <= 5'd0;
    end else begin
      state_r     <= state_next_s;
      red_cnt_r   <= red_next_s;
      black_cnt_r <= black_next_s;
      done_seen_r <= done_seen_next_s;
      init_busy_r <= (state_next_s == ST_FILL) || (state_next_s == ST_SHUFFLE);
      init_done_r <= (state_next_s == ST_DONE) && (state_r != ST_DONE);
      game_over_r <= ((state_next_s == ST_IDLE) || (state_next_s == ST_DONE)) &&
                     done_seen_next_s &&
                     ((red_next_s == 5'd0) || (black_next_s == 5'd0));
      // No write-through: a cell written this edge shows up one read later.
      rd_piece_r  <= cells_r[rd_addr];

      if (state_r == ST_FILL) begin
        fill_idx_r <= fill_idx_r + ADDR_W'(1);
      end else begin
        fill_idx_r <= '0;
      end

      if (state_r == ST_FILL) begin
        swap_j_r <= LAST_IDX;
      end else if ((state_r == ST_SHUFFLE) && swap_ok_s) begin
        swap_j_r <= swap_j_r - ADDR_W'(1);
      end

      if (state_r == ST_SHUFFLE) begin
        lfsr_r <= lfsr_next(lfsr_r);
      end else if (idle_s && seed_load) begin
        lfsr_r <= (seed_in == 16'h0000) ? SEED : seed_in;
      end
    end
  end

  // Cell array: fill, shuffle swaps, and game writes/uncovers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < N; k++) begin
        cells_r[k] <= 5'd0;
      end
    end else begin
      case (state_r)
        ST_FILL: begin
          cells_r[fill_idx_r] <= canon_cell(fill_idx_r);
        end
        ST_SHUFFLE: begin
          if (swap_ok_s) begin
            cells_r[swap_j_r] <= cells_r[swap_r_s];
            cells_r[swap_r_s] <= cells_r[swap_j_r];
          end
        end
        ST_IDLE, ST_DONE: begin
          if (uncover_en && (cells_r[uncover_addr][3:1] != 3'd0)) begin
            cells_r[uncover_addr] <= cells_r[uncover_addr] | 5'd1;
          end
          // Issued after the uncover so a same-address write takes priority.
          if (wr_en) begin
            cells_r[wr_addr] <= wr_piece;
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign board_flat[g*5 +: 5] = cells_r[g];
  end

  assign init_busy   = init_busy_r;
  assign init_done   = init_done_r;
  assign rd_piece    = rd_piece_r;
  assign red_count   = red_cnt_r;
  assign black_count = black_cnt_r;
  assign game_over   = game_over_r;

endmodule

// File: tb/tb_banqi_board_store.sv
// tb_banqi_board_store
//   Directed bench with two instances sharing the game-side inputs:
//   u_dut0 places canonically (SHUFFLE = 0), u_dut1 shuffles from SEED.
//   Each instance has its own init_start so the two init runs can be
//   sequenced independently.
module tb_banqi_board_store;

  localparam int N = 32;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         init_start0, init_start1, seed_load;
  logic [15:0]  seed_in;
  logic         wr_en, uncover_en;
  logic [4:0]   wr_addr, wr_piece, uncover_addr, rd_addr;

  logic         busy0, busy1, done0, done1, go0, go1;
  logic [4:0]   rd_piece0, rd_piece1, red0, red1, black0, black1;
  logic [N*5-1:0] flat0, flat1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [4:0] model_cells [N];
  int         model_rej;

  always #5 CLK = ~CLK;

  banqi_board_store #(.SHUFFLE(0)) u_dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .init_start(init_start0), .seed_load(seed_load),
    .seed_in(seed_in), .init_busy(busy0), .init_done(done0), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_piece(wr_piece), .uncover_en(uncover_en),
    .uncover_addr(uncover_addr), .rd_addr(rd_addr), .rd_piece(rd_piece0),
    .board_flat(flat0), .red_count(red0), .black_count(black0), .game_over(go0)
  );

  banqi_board_store #(.SHUFFLE(1), .SEED(16'hACE1)) u_dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .init_start(init_start1), .seed_load(seed_load),
    .seed_in(seed_in), .init_busy(busy1), .init_done(done1), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_piece(wr_piece), .uncover_en(uncover_en),
    .uncover_addr(uncover_addr), .rd_addr(rd_addr), .rd_piece(rd_piece1),
    .board_flat(flat1), .red_count(red1), .black_count(black1), .game_over(go1)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_cell(input int i);
    logic [2:0] p;
    case (i % 16)
      0:       p = 3'b111;
      1, 2:    p = 3'b110;
      3, 4:    p = 3'b101;
      5, 6:    p = 3'b011;
      7, 8:    p = 3'b100;
      9, 10:   p = 3'b010;
      default: p = 3'b001;
    endcase
    return {(i < 16) ? 1'b1 : 1'b0, p, 1'b0};
  endfunction

  function automatic logic [15:0] ref_lfsr(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [4:0] cell_of(input logic [N*5-1:0] flat, input int k);
    return flat[k*5 +: 5];
  endfunction

  // Fisher-Yates reference: r = low 5 LFSR bits before the step.
  task automatic build_model(input logic [15:0] seed);
    logic [15:0] x;
    logic [4:0]  r, tmp;
    int          j;
    for (int i = 0; i < N; i++) model_cells[i] = ref_cell(i);
    x = seed;
    j = 31;
    model_rej = 0;
    while (j >= 1) begin
      r = x[4:0];
      x = ref_lfsr(x);
      if (int'(r) <= j) begin
        tmp = model_cells[j];
        model_cells[j] = model_cells[r];
        model_cells[r] = tmp;
        j--;
      end else begin
        model_rej++;
      end
    end
  endtask

  // Start an init on one instance; count busy cycles and done pulses.
  // With inject set, game inputs and a new seed are driven mid-init.
  task automatic run_init(input bit which, input bit inject,
                          output int cycles, output int pulses);
    logic b, d;
    @(negedge CLK);
    if (which) init_start1 = 1'b1;
    else       init_start0 = 1'b1;
    @(negedge CLK);
    init_start0 = 1'b0;
    init_start1 = 1'b0;
    cycles = 0;
    pulses = 0;
    for (int k = 0; k < 2000; k++) begin
      b = which ? busy1 : busy0;
      d = which ? done1 : done0;
      if (b) cycles++;
      if (d) pulses++;
      if (!b && d) break;
      if (inject && (k == 5)) begin
        wr_en = 1'b1; wr_addr = 5'd0; wr_piece = 5'd0;
        uncover_en = 1'b1; uncover_addr = 5'd1;
        seed_load = 1'b1; seed_in = 16'h1234; init_start1 = 1'b1;
      end else begin
        wr_en = 1'b0; uncover_en = 1'b0; seed_load = 1'b0; init_start1 = 1'b0;
      end
      @(negedge CLK);
    end
    wr_en = 1'b0; uncover_en = 1'b0; seed_load = 1'b0; init_start1 = 1'b0;
  endtask

  task automatic write_cell(input logic [4:0] addr, input logic [4:0] piece);
    wr_en = 1'b1; wr_addr = addr; wr_piece = piece;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  int cyc, pul, exp_cycles;
  int red_list [16] = '{5, 16, 17, 18, 19, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31};

  initial begin
    init_start0 = 1'b0; init_start1 = 1'b0; seed_load = 1'b0; seed_in = 16'h0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_piece = 5'd0;
    uncover_en = 1'b0; uncover_addr = 5'd0; rd_addr = 5'd0;

    // Reset state
    repeat (3) @(negedge CLK);
    check_val("rst_busy",  32'(busy1), 32'd0);
    check_val("rst_done",  32'(done1), 32'd0);
    check_val("rst_rd",    32'(rd_piece1), 32'd0);
    check_val("rst_red",   32'(red1), 32'd0);
    check_val("rst_black", 32'(black1), 32'd0);
    check_val("rst_go",    32'(go1), 32'd0);
    check_val("rst_flat1", 32'(|flat1), 32'd0);
    check_val("rst_flat0", 32'(|flat0), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Canonical fill
    run_init(1'b0, 1'b0, cyc, pul);
    check_val("fill_cycles", 32'(cyc), 32'd32);
    check_val("fill_pulses", 32'(pul), 32'd1);
    @(negedge CLK);
    check_val("fill_done_width", 32'(done0), 32'd0);
    check_val("fill_cell0",  32'(cell_of(flat0, 0)),  32'b1_111_0);
    check_val("fill_cell16", 32'(cell_of(flat0, 16)), 32'b0_111_0);
    check_val("fill_cell31", 32'(cell_of(flat0, 31)), 32'b0_001_0);
    for (int k = 0; k < N; k++)
      check_val($sformatf("canon_cell%0d", k), 32'(cell_of(flat0, k)), 32'(ref_cell(k)));
    check_val("fill_red",   32'(red0), 32'd16);
    check_val("fill_black", 32'(black0), 32'd16);
    check_val("fill_go",    32'(go0), 32'd0);

    // Shuffled fill from SEED
    build_model(16'hACE1);
    exp_cycles = 32 + 31 + model_rej;
    run_init(1'b1, 1'b0, cyc, pul);
    check_val("shuf_cycles", 32'(cyc), 32'(exp_cycles));
    check_val("shuf_pulses", 32'(pul), 32'd1);
    @(negedge CLK);
    check_val("shuf_done_width", 32'(done1), 32'd0);
    for (int k = 0; k < N; k++)
      check_val($sformatf("shuf_cell%0d", k), 32'(cell_of(flat1, k)), 32'(model_cells[k]));
    check_val("shuf_red",   32'(red1), 32'd16);
    check_val("shuf_black", 32'(black1), 32'd16);

    // Move with capture on the canonical board
    write_cell(5'd3, 5'd0);
    check_val("mv_cell3",  32'(cell_of(flat0, 3)), 32'd0);
    check_val("mv_black1", 32'(black0), 32'd15);
    rd_addr = 5'd20;
    write_cell(5'd20, 5'b1_111_1);
    check_val("cap_red",     32'(red0), 32'd15);
    check_val("cap_black",   32'(black0), 32'd16);
    check_val("cap_cell20",  32'(cell_of(flat0, 20)), 32'b1_111_1);
    check_val("rd_old",      32'(rd_piece0), 32'b0_101_0);
    @(negedge CLK);
    check_val("rd_new",      32'(rd_piece0), 32'b1_111_1);

    // Write beats uncover on the same cell
    uncover_en = 1'b1; uncover_addr = 5'd5;
    write_cell(5'd5, 5'b0_001_0);
    uncover_en = 1'b0;
    check_val("wu_cell5", 32'(cell_of(flat0, 5)), 32'b0_001_0);
    check_val("wu_red",   32'(red0), 32'd16);
    check_val("wu_black", 32'(black0), 32'd15);
    // Uncover of an empty cell
    uncover_en = 1'b1; uncover_addr = 5'd3;
    @(negedge CLK);
    uncover_en = 1'b0;
    check_val("unc_empty", 32'(cell_of(flat0, 3)), 32'd0);
    // Write and uncover on different cells both apply
    uncover_en = 1'b1; uncover_addr = 5'd7;
    write_cell(5'd6, 5'd0);
    uncover_en = 1'b0;
    check_val("dual_cell6", 32'(cell_of(flat0, 6)), 32'd0);
    check_val("dual_cell7", 32'(cell_of(flat0, 7)), 32'b1_100_1);
    check_val("dual_black", 32'(black0), 32'd14);

    // Wipe out red
    for (int n = 0; n < 16; n++) begin
      if (n == 15) check_val("go_before", 32'(go0), 32'd0);
      write_cell(5'(red_list[n]), 5'd0);
      check_val($sformatf("wipe_red%0d", n), 32'(red0), 32'(15 - n));
    end
    check_val("go_after",    32'(go0), 32'd1);
    check_val("wipe_black",  32'(black0), 32'd14);

    // seed_in = 0 reproduces SEED; inputs during busy are ignored
    seed_load = 1'b1; seed_in = 16'h0000;
    @(negedge CLK);
    seed_load = 1'b0;
    run_init(1'b1, 1'b1, cyc, pul);
    check_val("reseed_cycles", 32'(cyc), 32'(exp_cycles));
    for (int k = 0; k < N; k++)
      check_val($sformatf("reseed_cell%0d", k), 32'(cell_of(flat1, k)), 32'(model_cells[k]));
    check_val("reseed_red",   32'(red1), 32'd16);
    check_val("reseed_black", 32'(black1), 32'd16);

    // Reset mid-shuffle
    @(negedge CLK);
    init_start1 = 1'b1;
    @(negedge CLK);
    init_start1 = 1'b0;
    repeat (40) @(negedge CLK);
    check_val("mid_busy", 32'(busy1), 32'd1);
    #1 RESET_N = 1'b0;
    #1;
    check_val("mid_rst_busy",  32'(busy1), 32'd0);
    check_val("mid_rst_flat",  32'(|flat1), 32'd0);
    check_val("mid_rst_red",   32'(red1), 32'd0);
    check_val("mid_rst_black", 32'(black1), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check_val("post_rst_busy", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
